// File: rtl/md_seq.sv
// Iterative 32-bit multiply/divide sequencer with start/busy/done handshake and EX stall.
// Optional divide datapath is built only when MD_SEQ_DIV_EN is defined.
module md_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_e;

  state_e               state_q, state_d;
  logic [5:0]           cnt_q, cnt_d;
  logic [WIDTH-1:0]     opb_q, opb_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic                 sa_q, sa_d, sb_q, sb_d;
  logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;

  logic                 accept;
  logic                 signed_op;
  logic [WIDTH-1:0]     a_abs, b_abs;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_step;
  logic [2*WIDTH-1:0]   prod_fix;

`ifdef MD_SEQ_DIV_EN
  logic                 div_q, div_d;
  logic [WIDTH-1:0]     opa_q, opa_d;
  logic [WIDTH:0]       div_top;
  logic                 div_ge;
  logic [WIDTH-1:0]     div_diff;
  logic [2*WIDTH-1:0]   div_step;
  logic [WIDTH-1:0]     quot, rem;
`endif

  always_comb begin
    signed_op = ~op[0];
    a_abs     = (signed_op && a[WIDTH-1]) ? -a : a;
    b_abs     = (signed_op && b[WIDTH-1]) ? -b : b;
    accept    = start & ((state_q == S_IDLE) | (state_q == S_DONE));

    // Shift-add: low half holds the remaining multiplier bits, high half accumulates.
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    mul_step  = {mul_sum, acc_q[WIDTH-1:1]};
    prod_fix  = (sa_q ^ sb_q) ? -acc_q : acc_q;

`ifdef MD_SEQ_DIV_EN
    // Restoring divide: the shifted-out remainder MSB is kept in div_top so no bit is lost.
    div_top   = acc_q[2*WIDTH-1:WIDTH-1];
    div_ge    = (div_top >= {1'b0, opb_q});
    div_diff  = div_top[WIDTH-1:0] - opb_q;
    div_step  = div_ge ? {div_diff, acc_q[WIDTH-2:0], 1'b1}
                       : {acc_q[2*WIDTH-2:0], 1'b0};
    quot      = acc_q[WIDTH-1:0];
    rem       = acc_q[2*WIDTH-1:WIDTH];
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opb_d   = opb_q;
    acc_d   = acc_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
`ifdef MD_SEQ_DIV_EN
    div_d   = div_q;
    opa_d   = opa_q;
`endif

    case (state_q)
      S_IDLE, S_DONE: state_d = S_IDLE;
      S_CALC: begin
        cnt_d = cnt_q + 6'd1;
`ifdef MD_SEQ_DIV_EN
        acc_d = div_q ? div_step : mul_step;
`else
        acc_d = mul_step;
`endif
        if (cnt_q == 6'(WIDTH - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_DONE;
`ifdef MD_SEQ_DIV_EN
        if (div_q) begin
          if (opb_q == '0) begin
            lo_d = '1;
            hi_d = sa_q ? -opa_q : opa_q;
          end else begin
            lo_d = (sa_q ^ sb_q) ? -quot : quot;
            hi_d = sa_q ? -rem : rem;
          end
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
`else
        {hi_d, lo_d} = prod_fix;
`endif
      end
      default: state_d = S_IDLE;
    endcase

    if (accept) begin
      sa_d  = signed_op & a[WIDTH-1];
      sb_d  = signed_op & b[WIDTH-1];
      opb_d = b_abs;
      cnt_d = '0;
      acc_d = {{WIDTH{1'b0}}, a_abs};
`ifdef MD_SEQ_DIV_EN
      opa_d   = a_abs;
      div_d   = op[1];
      state_d = S_CALC;
`else
      // Without the divide datapath a divide request completes at once, leaving hi/lo untouched.
      state_d = op[1] ? S_DONE : S_CALC;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      opb_q   <= '0;
      acc_q   <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
`ifdef MD_SEQ_DIV_EN
      div_q   <= 1'b0;
      opa_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opb_q   <= opb_d;
      acc_q   <= acc_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
`ifdef MD_SEQ_DIV_EN
      div_q   <= div_d;
      opa_q   <= opa_d;
`endif
    end
  end

  assign busy  = (state_q == S_CALC) | (state_q == S_FIX);
  assign done  = (state_q == S_DONE);
  assign stall = busy | accept;
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule

// File: tb/tb_md_seq.sv
// Directed and randomized bench for md_seq against an arithmetic reference model.
module tb_md_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        busy, stall, done;
  logic [31:0] hi, lo;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  int          m_lat;

`ifdef MD_SEQ_DIV_EN
  localparam logic [1:0] GL_OP = 2'd3;
`else
  localparam logic [1:0] GL_OP = 2'd1;
`endif

  md_seq #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .stall (stall),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference results straight from the arithmetic definitions of each op.
  task automatic model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint      p;
    logic [63:0] u;
    int          sx, sy;
    m_lat = 34;
    case (o)
      2'd0: begin
        p = longint'($signed(x)) * longint'($signed(y));
        {m_hi, m_lo} = p;
      end
      2'd1: begin
        u = {32'd0, x} * {32'd0, y};
        {m_hi, m_lo} = u;
      end
      default: begin
`ifdef MD_SEQ_DIV_EN
        if (y == 32'd0) begin
          m_lo = '1;
          m_hi = x;
        end else if (o == 2'd3) begin
          m_lo = x / y;
          m_hi = x % y;
        end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
          m_lo = 32'h8000_0000;
          m_hi = '0;
        end else begin
          sx = x;
          sy = y;
          m_lo = sx / sy;
          m_hi = sx % sy;
        end
`else
        m_lat = 1;
`endif
      end
    endcase
  endtask

  // Called at a negedge; issues the op and follows it to its done cycle.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input bit glitch, input bit chain);
    int lat;
    model(o, x, y);
    start = 1'b1; op = o; a = x; b = y;
    #1 chk("stall_accept", stall, 1);
    @(posedge clk);
    #1 start = 1'b0; a = $urandom; b = $urandom; op = 2'($urandom);
    lat = 0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (done) begin
        lat = n;
        break;
      end
      chk("busy_mid", busy, 1);
      chk("stall_mid", stall, 1);
      if (glitch && (n == 5 || n == 20)) begin
        start = 1'b1; a = $urandom; b = $urandom; op = 2'($urandom);
      end else begin
        start = 1'b0;
      end
    end
    chk("latency", lat, m_lat);
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
    chk("busy_done", busy, 0);
    if (!chain) begin
      chk("stall_done", stall, 0);
      @(negedge clk);
      chk("done_single", done, 0);
      chk("hi_hold", hi, m_hi);
      chk("lo_hold", lo, m_lo);
    end
  endtask

  initial begin
    int          cnt;
    logic [31:0] edges [4];
    logic [31:0] ra, rb;
    edges[0] = 32'h0000_0000; edges[1] = 32'h0000_0001;
    edges[2] = 32'hFFFF_FFFF; edges[3] = 32'h8000_0000;

    rst = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
    #2 rst = 1'b1;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_stall", stall, 0);
    chk("rst_done", done, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
    run_op(2'd0, -32'sd3, 32'd5, 0, 0);
    run_op(2'd0, 32'h8000_0000, 32'h8000_0000, 0, 0);
    run_op(2'd2, -32'sd7, 32'd2, 0, 0);
    run_op(2'd3, 32'd100, 32'd0, 0, 0);
    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    run_op(2'd2, -32'sd7, 32'd0, 0, 0);
    run_op(2'd2, 32'd45, -32'sd7, 0, 0);

    // Starts while busy must be ignored; the follow-up starts in the done cycle.
    run_op(GL_OP, 32'd10, 32'd3, 1, 1);
    run_op(2'd0, 32'h7FFF_FFFF, -32'sd2, 0, 0);

    // Asynchronous reset mid-multiply.
    run_op(2'd1, 32'd7, 32'd9, 0, 0);
    start = 1'b1; op = 2'd0; a = 32'h1234_5678; b = 32'h0BAD_F00D;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_hi", hi, 0);
    chk("arst_lo", lo, 0);
    chk("arst_stall", stall, 0);
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) cnt++;
    end
    chk("no_done_after_rst", cnt, 0);
    run_op(2'd0, -32'sd12345, 32'd678, 0, 0);

    for (int i = 0; i < 16; i++) begin
      ra = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 3)] : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 3)] : $urandom;
      if ($urandom_range(0, 1) == 1) rb = rb >> $urandom_range(0, 31);
      run_op(2'($urandom), ra, rb, 0, ($urandom_range(0, 2) == 0));
    end
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/md_seq.md
# md_seq

Multi-cycle multiply/divide sequencer for the pipeline CPU's execute stage. It runs 32-bit signed and unsigned multiply and divide as iterative shift-add and restoring-divide loops, one bit per cycle, with a start/busy/done handshake. It drives a stall signal so the pipeline holds the instruction in EX until the HI/LO results are written. It sits beside the single-cycle ALU and shares its operand buses.

## Interface
- `WIDTH`, 32, operand and result width; only 32 is supported.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request to begin an operation; sampled on a rising edge.
- `op`  in  2  operation select: 0 = MULT (signed), 1 = MULTU, 2 = DIV (signed), 3 = DIVU.
- `a`  in  WIDTH  first operand (multiplicand or dividend); sampled only when start is accepted.
- `b`  in  WIDTH  second operand (multiplier or divisor); sampled only when start is accepted.
- `busy`  out  1  operation in progress.
- `stall`  out  1  pipeline hold, equal to `busy | (start & accept)`.
- `done`  out  1  one-cycle pulse; `hi` and `lo` are valid while it is high.
- `hi`  out  WIDTH  product upper 32 bits, or remainder.
- `lo`  out  WIDTH  product lower 32 bits, or quotient.

## Operation
- **States:** IDLE, CALC, FIX, DONE.
- **Accept rule:** `accept = start & (state == IDLE | state == DONE)`. While `busy` is high, `start` is ignored and the operands are not resampled.
- **On accept:**
  - Latch `op`.
  - For signed ops, latch the absolute values of `a` and `b` and record the sign flags.
  - Clear the 6-bit counter.
  - Go to CALC.
- **CALC multiply:** 64-bit accumulator with shift-add, examining one multiplier bit per cycle.
- **CALC divide:** restoring divide on a 64-bit remainder/quotient register, producing one quotient bit per cycle.
- **CALC exit:** after 32 iterations (counter == 31 at the edge), go to FIX.
- **FIX (signed ops only; unsigned ops pass through unchanged):**
  - Multiply: negate the 64-bit product if the operand signs differ.
  - Divide: negate the quotient if the operand signs differ; give the remainder the dividend's sign.
- **Result load:** the FIX→DONE edge loads `hi`/`lo`.
- **DONE:** lasts one cycle, then returns to IDLE unless a new start is accepted.
- **Divide by zero:** `lo = 32'hFFFFFFFF`, `hi = a` (original, unsigned interpretation). Latency is unchanged.
- **Signed overflow:** `32'h80000000 / -1` gives `lo = 32'h80000000`, `hi = 0`.
- **Result hold:** `hi`/`lo` keep their value until the next DONE. They are never partially updated.
- **Reset (asynchronous, including mid-operation):**
  - state = IDLE.
  - `busy`, `done`, `hi`, `lo` = 0; the counter and internal registers are cleared.
  - The in-flight operation is discarded.

## Timing
- **Edge E0 accepts start:**
  - `busy` is high after E0 through E33 (33 cycles).
  - E1–E32 are CALC; E33 is FIX→DONE.
  - `done` is high for exactly one cycle after E33, and `busy` is low during that cycle.
- **Latency:** 34 cycles from start to `done`.
- **Back-to-back:** a start accepted in the `done` cycle is the next E0. Throughput is one operation per 34 cycles.
- **Stall:** `stall` rises combinationally in the accept cycle, so the EX instruction is held from E0 onward. It is low in the `done` cycle unless a new start is accepted.
- **Output reset values:** `busy` = 0, `stall` = 0 (with `start` low), `done` = 0, `hi` = 0, `lo` = 0.

## Configuration
- **Macro:** `MD_SEQ_DIV_EN`.
- **Defined:** ops 2 and 3 perform division as above.
- **Undefined:**
  - The divide datapath is not built.
  - A start with `op[1] = 1` is accepted; `busy` stays 0, `done` pulses on the next cycle, and `hi`/`lo` are unchanged.
  - Multiply behaviour and latency are identical to the defined case.

## Test plan
- MULTU, `a = b = 32'hFFFFFFFF` → `done` 34 cycles after start; `hi = 32'hFFFFFFFE`, `lo = 32'h00000001`.
- MULT, `a = -3`, `b = 5` → `hi = 32'hFFFFFFFF`, `lo = 32'hFFFFFFF1`. Then MULT `32'h80000000 × 32'h80000000` → `hi = 32'h40000000`, `lo = 0`.
- DIV, `a = -7`, `b = 2` → `lo = 32'hFFFFFFFD`, `hi = 32'hFFFFFFFF`. DIVU, `a = 100`, `b = 0` → `lo = 32'hFFFFFFFF`, `hi = 100`.
- Start DIVU `10/3`; pulse `start` with new operands at cycles 5 and 20 → both ignored; result `lo = 3`, `hi = 1`, exactly one `done`. Then start in the `done` cycle → second `done` 34 cycles later.
- Start MULT; assert `rst` at cycle 10 → `busy`, `done`, `hi`, `lo` = 0 immediately (asynchronous); no `done` follows. A fresh start after release gives the correct result.
- With `MD_SEQ_DIV_EN` undefined, DIV start → `done` after 1 cycle, `hi`/`lo` unchanged, `busy` never high.
